// File: rtl/beh_comp_if.sv
// Operand/result bundle for the beh_comp signed comparator.
// Build option COMP_UNSIGNED_MODE_EN adds the per-transaction uns select.
interface beh_comp_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cnt_clr;
`ifdef COMP_UNSIGNED_MODE_EN
    logic             uns;
`endif
    logic             Gt;
    logic             Eq;
    logic             Lt;
    logic             out_valid;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] lt_cnt;

    modport master (
        output in_valid, A, B, cnt_clr,
`ifdef COMP_UNSIGNED_MODE_EN
        output uns,
`endif
        input  Gt, Eq, Lt, out_valid, gt_cnt, eq_cnt, lt_cnt
    );

    modport slave (
        input  in_valid, A, B, cnt_clr,
`ifdef COMP_UNSIGNED_MODE_EN
        input  uns,
`endif
        output Gt, Eq, Lt, out_valid, gt_cnt, eq_cnt, lt_cnt
    );
endinterface

// File: rtl/beh_comp.sv
// Registered signed comparator with one-hot Gt/Eq/Lt flags and saturating outcome counters.
// Build option COMP_UNSIGNED_MODE_EN enables the per-transaction unsigned compare via bus.uns.
module beh_comp #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input logic       clk,
    input logic       rst_n,
    beh_comp_if.slave bus
);
    logic uns_sel;
`ifdef COMP_UNSIGNED_MODE_EN
    assign uns_sel = bus.uns;
`else
    assign uns_sel = 1'b0;
`endif

    // One extra bit lets a single signed compare cover both modes:
    // sign-extend for signed, zero-extend for unsigned.
    logic signed [WIDTH:0] a_ext;
    logic signed [WIDTH:0] b_ext;
    assign a_ext = {~uns_sel & bus.A[WIDTH-1], bus.A};
    assign b_ext = {~uns_sel & bus.B[WIDTH-1], bus.B};

    // hit index: 2 = greater, 1 = equal, 0 = less
    logic [2:0] hit;
    assign hit[2] = (a_ext > b_ext);
    assign hit[1] = (a_ext == b_ext);
    assign hit[0] = (a_ext < b_ext);

    logic [2:0] flags_reg;
    logic       out_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_reg     <= 3'b000;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                flags_reg <= hit;
            end
        end
    end

    logic [2:0][CNT_W-1:0] cnt_all;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            // Clear has priority over a coincident count.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (bus.cnt_clr) begin
                    cnt_reg <= '0;
                end else if (bus.in_valid && hit[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign cnt_all[gi] = cnt_reg;
        end
    endgenerate

    assign bus.Gt        = flags_reg[2];
    assign bus.Eq        = flags_reg[1];
    assign bus.Lt        = flags_reg[0];
    assign bus.out_valid = out_valid_reg;
    assign bus.gt_cnt    = cnt_all[2];
    assign bus.eq_cnt    = cnt_all[1];
    assign bus.lt_cnt    = cnt_all[0];
endmodule

// File: tb/tb_beh_comp.sv
// Directed bench for beh_comp: one DUT at CNT_W=8 and a CNT_W=2 twin sharing the same stimulus.
module tb_beh_comp;
    logic clk;
    logic rst_n;

    beh_comp_if #(.WIDTH(4), .CNT_W(8)) bus  ();
    beh_comp_if #(.WIDTH(4), .CNT_W(2)) bus2 ();

    beh_comp #(.WIDTH(4), .CNT_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    beh_comp #(.WIDTH(4), .CNT_W(2)) u_dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    assign bus2.in_valid = bus.in_valid;
    assign bus2.A        = bus.A;
    assign bus2.B        = bus.B;
    assign bus2.cnt_clr  = bus.cnt_clr;
`ifdef COMP_UNSIGNED_MODE_EN
    assign bus2.uns      = bus.uns;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {Gt, Eq, Lt, out_valid}
    function automatic logic [31:0] flags();
        return {28'd0, bus.Gt, bus.Eq, bus.Lt, bus.out_valid};
    endfunction

    // {gt_cnt, eq_cnt, lt_cnt}
    function automatic logic [31:0] cnts8();
        return {8'd0, bus.gt_cnt, bus.eq_cnt, bus.lt_cnt};
    endfunction

    function automatic logic [31:0] cnts2();
        return {26'd0, bus2.gt_cnt, bus2.eq_cnt, bus2.lt_cnt};
    endfunction

    task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b, input logic clr);
        bus.in_valid = v;
        bus.A        = a;
        bus.B        = b;
        bus.cnt_clr  = clr;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.cnt_clr  = 1'b0;
        $display("step v=%0b A=%h B=%h clr=%0b -> Gt=%0b Eq=%0b Lt=%0b ov=%0b cnt=%0d/%0d/%0d", v, a, b, clr,
                 bus.Gt, bus.Eq, bus.Lt, bus.out_valid, bus.gt_cnt, bus.eq_cnt, bus.lt_cnt);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.A        = 4'h0;
        bus.B        = 4'h0;
        bus.cnt_clr  = 1'b0;
`ifdef COMP_UNSIGNED_MODE_EN
        bus.uns      = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", flags(), 32'h0);
        chk("reset_cnt", cnts8(), 32'h0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic ordering, latency 1
        step(1'b1, 4'h2, 4'h1, 1'b0);
        chk("t1_flags", flags(), 32'b1001);
        chk("t1_cnt", cnts8(), {8'd0, 8'd1, 8'd0, 8'd0});
        step(1'b1, 4'h1, 4'h2, 1'b0);
        chk("lt_1_2", flags(), 32'b0011);
        step(1'b1, 4'h3, 4'h3, 1'b0);
        chk("eq_3_3", flags(), 32'b0101);
        step(1'b1, 4'hF, 4'hE, 1'b0);   // -1 vs -2
        chk("gt_m1_m2", flags(), 32'b1001);
        step(1'b1, 4'hE, 4'hF, 1'b0);   // -2 vs -1
        chk("lt_m2_m1", flags(), 32'b0011);
        step(1'b1, 4'hD, 4'hD, 1'b0);   // -3 vs -3
        chk("eq_m3_m3", flags(), 32'b0101);
        chk("cnt_seq2", cnts8(), {8'd0, 8'd2, 8'd2, 8'd2});

        // mixed signs and extremes
        step(1'b1, 4'h1, 4'hF, 1'b0);
        chk("gt_1_m1", flags(), 32'b1001);
        step(1'b1, 4'hF, 4'h1, 1'b0);
        chk("lt_m1_1", flags(), 32'b0011);
        step(1'b1, 4'h8, 4'h7, 1'b0);   // -8 vs 7
        chk("lt_m8_7", flags(), 32'b0011);
        step(1'b1, 4'h7, 4'h8, 1'b0);
        chk("gt_7_m8", flags(), 32'b1001);
        chk("cnt_seq3", cnts8(), {8'd0, 8'd4, 8'd2, 8'd4});
        chk("cnt_sat_seq3", cnts2(), {26'd0, 2'd3, 2'd2, 2'd3});

        // idle cycles: flags hold, out_valid drops, operands ignored
        step(1'b0, 4'bxxxx, 4'h5, 1'b0);
        chk("idle_x_flags", flags(), 32'b1000);
        step(1'b0, 4'h0, 4'h7, 1'b0);
        chk("idle_flags", flags(), 32'b1000);
        chk("idle_cnt", cnts8(), {8'd0, 8'd4, 8'd2, 8'd4});

        // asynchronous reset mid-stream
        step(1'b1, 4'h0, 4'h0, 1'b0);
        chk("pre_rst_eq", flags(), 32'b0101);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_flags", flags(), 32'h0);
        chk("async_rst_cnt", cnts8(), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(1'b0, 4'h3, 4'h1, 1'b0);
        chk("post_rst_idle", flags(), 32'h0);

        // saturation on the CNT_W=2 twin
        for (int i = 0; i < 3; i++) step(1'b1, 4'h3, 4'h0, 1'b0);
        chk("sat3_cnt2", cnts2(), {26'd0, 2'd3, 2'd0, 2'd0});
        for (int i = 0; i < 2; i++) step(1'b1, 4'h3, 4'h0, 1'b0);
        chk("sat5_cnt2", cnts2(), {26'd0, 2'd3, 2'd0, 2'd0});
        chk("sat5_cnt8", cnts8(), {8'd0, 8'd5, 8'd0, 8'd0});

        // clear wins over a coincident count; flags still update
        step(1'b1, 4'hC, 4'h2, 1'b1);   // -4 vs 2
        chk("clr_valid_flags", flags(), 32'b0011);
        chk("clr_valid_cnt8", cnts8(), 32'h0);
        chk("clr_valid_cnt2", cnts2(), 32'h0);
        step(1'b1, 4'h0, 4'h0, 1'b0);
        chk("after_clr_cnt", cnts8(), {8'd0, 8'd0, 8'd1, 8'd0});
        step(1'b0, 4'h9, 4'h1, 1'b1);
        chk("clr_idle_flags", flags(), 32'b0100);
        chk("clr_idle_cnt", cnts8(), 32'h0);

`ifdef COMP_UNSIGNED_MODE_EN
        bus.uns = 1'b1;
        step(1'b1, 4'hF, 4'h1, 1'b0);
        chk("uns_gt", flags(), 32'b1001);
        bus.uns = 1'b0;
        step(1'b1, 4'hF, 4'h1, 1'b0);
        chk("sgn_lt", flags(), 32'b0011);
        bus.uns = 1'b1;
        step(1'b1, 4'h8, 4'h7, 1'b0);
        chk("uns_gt_8_7", flags(), 32'b1001);
        bus.uns = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
